// File: rtl/mtx_pkg.sv
// Shared FSM state type and width helpers for the matrix job dispatcher.
package mtx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Width of a credit counter that must hold 0..max_jobs inclusive.
   function automatic int credit_w(input int max_jobs);
      return $clog2(max_jobs + 1);
   endfunction

   function automatic int sel_w(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

endpackage

// File: rtl/mtx_rr_arb.sv
// Combinational round-robin picker: first eligible channel at or after rr_ptr,
// wrapping to the lowest eligible channel when nothing at/above rr_ptr is set.
module mtx_rr_arb
   import mtx_pkg::*;
#(
   parameter  int NUM_CH = 32,
   localparam int SEL_W  = sel_w(NUM_CH)
) (
   input  logic [NUM_CH-1:0] eligible,
   input  logic [SEL_W-1:0]  rr_ptr,
   output logic              grant_valid,
   output logic [SEL_W-1:0]  grant
);

   logic [NUM_CH-1:0] upper_mask;
   logic [NUM_CH-1:0] upper_req;

   always_comb begin
      upper_mask = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         upper_mask[i] = (SEL_W'(i) >= rr_ptr);
      end
   end

   assign upper_req = eligible & upper_mask;

   // Descending scan so the lowest matching index is the one that sticks.
   always_comb begin
      grant_valid = |eligible;
      grant       = '0;
      if (|upper_req) begin
         for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (upper_req[i]) grant = SEL_W'(i);
         end
      end else begin
         for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (eligible[i]) grant = SEL_W'(i);
         end
      end
   end

endmodule

// File: rtl/mtx_dispatch.sv
// Job distributor: picks a channel per job round-robin among channels with credit,
// forwards the job's beats through a one-entry output register. Optional counters: MTX_DISPATCH_STATS_EN.
module mtx_dispatch
   import mtx_pkg::*;
#(
   parameter int NUM_CH     = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_JOBS   = 4
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic                  test_mode_en,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   output logic [NUM_CH-1:0]     out_valid,
   input  logic [NUM_CH-1:0]     out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   input  logic [NUM_CH-1:0]     credit_ret,
   output logic                  busy,
   output logic                  err_credit_ovf,
   output logic [1:0]            dbg_state
`ifdef MTX_DISPATCH_STATS_EN
   ,
   output logic [31:0]           stat_jobs,
   output logic [31:0]           stat_stall
`endif
);

   localparam int                  CREDIT_W   = credit_w(MAX_JOBS);
   localparam int                  SEL_W      = sel_w(NUM_CH);
   localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(MAX_JOBS);
   localparam logic [SEL_W-1:0]    LAST_CH    = SEL_W'(NUM_CH - 1);

   state_t                  state, state_nxt;
   logic [SEL_W-1:0]        sel, sel_nxt;
   logic [SEL_W-1:0]        rr_ptr, rr_ptr_nxt;
   logic [CREDIT_W-1:0]     credit [NUM_CH];
   logic [NUM_CH-1:0]       eligible;
   logic [NUM_CH-1:0]       consume;
   logic                    grant_valid;
   logic [SEL_W-1:0]        grant;
   logic                    obuf_valid;
   logic [DATA_WIDTH-1:0]   obuf_data;
   logic                    obuf_last;
   logic                    accept;
   logic                    pop;

   always_comb begin
      eligible = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         eligible[ch] = (credit[ch] != '0) && (!test_mode_en || (ch == 0));
      end
   end

   mtx_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
      .eligible    (eligible),
      .rr_ptr      (rr_ptr),
      .grant_valid (grant_valid),
      .grant       (grant)
   );

   // Handshakes: a beat moves on a rising edge where valid and ready are both high.
   assign pop    = obuf_valid && out_ready[sel];
   assign accept = in_valid && in_ready;

   always_comb begin
      state_nxt  = state;
      sel_nxt    = sel;
      rr_ptr_nxt = rr_ptr;
      consume    = '0;
      in_ready   = 1'b0;
      unique case (state)
         IDLE: begin
            if (in_valid && grant_valid) begin
               sel_nxt        = grant;
               consume[grant] = 1'b1;
               state_nxt      = SEND;
            end
         end
         SEND: begin
            in_ready = !obuf_valid || out_ready[sel];
            if (in_valid && in_ready && in_last) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (!obuf_valid || pop) begin
               rr_ptr_nxt = (sel == LAST_CH) ? '0 : sel + 1'b1;
               state_nxt  = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state  <= IDLE;
         sel    <= '0;
         rr_ptr <= '0;
      end else begin
         state  <= state_nxt;
         sel    <= sel_nxt;
         rr_ptr <= rr_ptr_nxt;
      end
   end

   // A consume and a return on the same channel cancel; a return at full credit is dropped.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         for (int ch = 0; ch < NUM_CH; ch++) credit[ch] <= CREDIT_MAX;
         err_credit_ovf <= 1'b0;
      end else begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if (consume[ch] && !credit_ret[ch]) begin
               credit[ch] <= credit[ch] - 1'b1;
            end else if (credit_ret[ch] && !consume[ch]) begin
               if (credit[ch] == CREDIT_MAX) err_credit_ovf <= 1'b1;
               else                          credit[ch] <= credit[ch] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         obuf_valid <= 1'b0;
         obuf_data  <= '0;
         obuf_last  <= 1'b0;
      end else if (accept) begin
         obuf_valid <= 1'b1;
         obuf_data  <= in_data;
         obuf_last  <= in_last;
      end else if (pop) begin
         obuf_valid <= 1'b0;
      end
   end

   always_comb begin
      out_valid = '0;
      if (obuf_valid) out_valid[sel] = 1'b1;
   end

   assign out_data  = obuf_data;
   assign out_last  = obuf_last;
   assign busy      = (state != IDLE) || obuf_valid;
   assign dbg_state = state;

`ifdef MTX_DISPATCH_STATS_EN
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         stat_jobs  <= '0;
         stat_stall <= '0;
      end else if (state == IDLE && in_valid) begin
         if (grant_valid) stat_jobs  <= stat_jobs + 32'd1;
         else             stat_stall <= stat_stall + 32'd1;
      end
   end
`endif

endmodule

// File: doc/mtx_dispatch.md
Name: mtx_dispatch

Overview:
- Job distributor that sits directly upstream of the matrix sub-system's NUM_CH mapu_top channels.
- Accepts a single stream of job beats from the host fabric and chooses one channel per job. Channels are picked round-robin among those holding a free credit.
- Forwards all beats of the job to that channel through a one-entry output register.
- Tracks outstanding jobs per channel with credits that the channels return on completion.

Parameters:
NUM_CH, 32, number of mapu channels served
DATA_WIDTH, 32, job beat payload width
MAX_JOBS, 4, credits per channel (max outstanding jobs per channel), >=1

Ports:
sys_clk  input  1  system clock, all logic on rising edge
sys_rst_n  input  1  asynchronous active-low reset
test_mode_en  input  1  restricts dispatch to channel 0 only
in_valid  input  1  job beat valid
in_ready  output  1  job beat accepted when in_valid && in_ready
in_data  input  DATA_WIDTH  job beat payload
in_last  input  1  final beat of job
out_valid  output  NUM_CH  one-hot per-channel beat valid
out_ready  input  NUM_CH  per-channel ready
out_data  output  DATA_WIDTH  shared beat payload
out_last  output  1  shared final-beat flag
credit_ret  input  NUM_CH  per-channel one-cycle pulse: job complete, return one credit
busy  output  1  state != IDLE or output register occupied
err_credit_ovf  output  1  sticky: credit returned to a channel already at MAX_JOBS

Behaviour:
- Reset (async assert, sync-free deassert handling upstream):
  - all outputs 0
  - state=IDLE
  - rr_ptr=0
  - every credit counter=MAX_JOBS
  - output register empty
- Counter widths: CREDIT_W=$clog2(MAX_JOBS+1), SEL_W=$clog2(NUM_CH) (min 1).
- Eligibility: ch eligible iff credit[ch]>0 and (test_mode_en==0 or ch==0).
- FSM:
  - IDLE: in_ready=0. If in_valid and any channel eligible:
    - sel = first eligible channel at or after rr_ptr, with wrap-around from NUM_CH-1 to 0
    - credit[sel] decremented
    - next state SEND
    - Otherwise stay IDLE.
  - SEND: in_ready = !obuf_valid || out_ready[sel].
    - On accept: obuf loads in_data/in_last, obuf_valid=1.
    - On accept with in_last=1: next state DRAIN.
  - DRAIN: in_ready=0. When obuf empties, or empties this cycle via out_ready[sel]:
    - rr_ptr = (sel+1) mod NUM_CH
    - next state IDLE
- Output register:
  - out_valid = obuf_valid ? onehot(sel) : 0
  - out_data/out_last driven from obuf
  - Beat leaves when out_ready[sel]=1. A simultaneous load and drain in the same cycle keeps obuf_valid=1 with the new beat.
  - Data held stable while out_valid && !out_ready.
- Latency: beat accepted in cycle N appears on out_* in cycle N+1. Minimum per-job overhead is 1 IDLE cycle plus 1 DRAIN cycle.
- Single-beat jobs (first beat has in_last=1) go directly SEND->DRAIN.
- Credits:
  - A return and a consume on the same channel in the same cycle leave the counter unchanged.
  - A return to a counter at MAX_JOBS is dropped (saturate) and sets err_credit_ovf, which clears only on reset.
  - Returns on non-selected channels are processed in parallel every cycle.
- test_mode_en only affects selection in IDLE; a change mid-job does not redirect the current job.
- No channel eligible: the block stalls in IDLE with in_ready=0 indefinitely; no beat is dropped.
- Reset mid-job discards the obuf contents and restores all credits; upstream and channels are reset together.

Optional Feature:
MTX_DISPATCH_STATS_EN:
- Defined: adds output ports stat_jobs[31:0] and stat_stall[31:0].
  - stat_jobs increments on each IDLE->SEND transition.
  - stat_stall increments on each IDLE cycle with in_valid=1 and no eligible channel.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- mtx_pkg holds:
  - state enum (IDLE, SEND, DRAIN)
  - CREDIT_W/SEL_W width helper functions
- Sub-module mtx_rr_arb:
  - parameter NUM_CH
  - inputs: eligible vector, rr_ptr
  - outputs: grant_valid, grant index
  - purely combinational masked-priority picker
- mtx_dispatch holds the FSM, credits, obuf and stats.

Test Plan:
- Reset, then 3 single-beat jobs with all out_ready=1 -> jobs land on ch0, ch1, ch2 in order; each out beat 1 cycle after accept; credit[0..2]=3.
- NUM_CH=4, MAX_JOBS=2, no credit_ret, 9 jobs -> 8 dispatched (ch0,1,2,3,0,1,2,3); 9th stalls with in_ready=0. Then pulse credit_ret[2] -> 9th job goes to ch2 (first eligible at or after rr_ptr=0).
- 4-beat job with out_ready[sel] low for 3 cycles after beat 2 -> out_data holds beat 2 stable, in_ready=0 while obuf full, all 4 beats delivered in order, out_last only on beat 4.
- credit_ret[0] at credit=MAX_JOBS -> err_credit_ovf=1 and stays set. Credit consume and return on ch1 in the same cycle -> credit[1] unchanged.
- test_mode_en=1, 3 jobs -> all go to ch0. Once ch0 credits are exhausted, the stream stalls even though ch1..ch31 have credits.
- Assert sys_rst_n mid-job (after beat 2 of 4) -> out_valid=0 and busy=0 immediately; after release, credits=MAX_JOBS and the next job goes to ch0.
